hilo_muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/div_iter.sv | 27 ++
 rtl/hilo_muldiv_unit.sv | 122 ++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply/divide unit
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } muldiv_op_t;
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;
    localparam int DIV_ITERS = 32;
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider datapath, one quotient bit per step
module div_iter (
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic [31:0] dvs;
    logic [32:0] sh;
    logic        ge;
    assign sh = {remainder, quotient[31]};
    assign ge = sh >= {1'b0, dvs};
    // load operands, then shift in one quotient bit per step, restoring on a failed subtract
    always_ff @(posedge clk) begin
        if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
        end else if (step) begin
            quotient  <= {quotient[30:0], ge};
            remainder <= ge ? sh[31:0] - dvs : sh[31:0];
        end
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO owner with multi-cycle multiply and iterative divide; HILO_FWD_EN adds same-cycle HI/LO bypass
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  muldiv_op_t  op_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        cancel_i,
    output logic        ready_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o
);
    localparam logic [5:0] MUL_LAST = 6'(MUL_STAGES - 1);
    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] hi_q, lo_q, hi_nxt, lo_nxt;
    logic [31:0] mul_a, mul_b, div_raw, a_mag, b_mag, quo, rem, q_fix, r_fix;
    logic [63:0] ext_a, ext_b, prod;
    logic        mul_sgn, q_neg, r_neg, div_zero;
    logic        accept, is_mul, is_div, wr_hi, wr_lo, wr_res;
    assign ready_o = state == S_IDLE;
    assign accept  = valid_i && ready_o && !cancel_i && op_i != OP_NONE;
    assign is_mul  = op_i == OP_MULT || op_i == OP_MULTU;
    assign is_div  = op_i == OP_DIV || op_i == OP_DIVU;
    assign a_mag   = (op_i == OP_DIV && reg1_i[31]) ? -reg1_i : reg1_i;
    assign b_mag   = (op_i == OP_DIV && reg2_i[31]) ? -reg2_i : reg2_i;
    assign ext_a   = {{32{mul_sgn & mul_a[31]}}, mul_a};
    assign ext_b   = {{32{mul_sgn & mul_b[31]}}, mul_b};
    assign prod    = ext_a * ext_b;
    assign q_fix   = q_neg ? -quo : quo;
    assign r_fix   = r_neg ? -rem : rem;
    div_iter u_div (
        .clk       (clk),
        .load      (accept && is_div),
        .step      (state == S_DIV),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );
    // state register and per-operation step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 6'd0 : cnt + 6'd1;
        end
    end
    // next state and HI/LO write decisions; cancel wins over any completion
    always_comb begin
        state_nxt = state;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        wr_res    = 1'b0;
        hi_nxt    = reg1_i;
        lo_nxt    = reg1_i;
        case (state)
            S_IDLE: begin
                wr_hi     = accept && op_i == OP_MTHI;
                wr_lo     = accept && op_i == OP_MTLO;
                state_nxt = !accept ? S_IDLE : is_mul ? S_MUL : is_div ? S_DIV : S_IDLE;
            end
            S_MUL: begin
                wr_res    = cnt == MUL_LAST;
                state_nxt = wr_res ? S_IDLE : S_MUL;
                hi_nxt    = prod[63:32];
                lo_nxt    = prod[31:0];
            end
            S_DIV: state_nxt = (div_zero || cnt == DIV_LAST) ? S_FIX : S_DIV;
            S_FIX: begin
                wr_res    = 1'b1;
                state_nxt = S_IDLE;
                hi_nxt    = div_zero ? div_raw : r_fix;
                lo_nxt    = div_zero ? DIV_ZERO_LO : q_fix;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (cancel_i) state_nxt = S_IDLE;
        wr_res = wr_res && !cancel_i;
        wr_hi  = wr_hi || wr_res;
        wr_lo  = wr_lo || wr_res;
    end
    // capture operands and result sign information on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            mul_a    <= reg1_i;
            mul_b    <= reg2_i;
            mul_sgn  <= op_i == OP_MULT;
            div_raw  <= reg1_i;
            div_zero <= reg2_i == 32'd0;
            q_neg    <= op_i == OP_DIV && (reg1_i[31] ^ reg2_i[31]);
            r_neg    <= op_i == OP_DIV && reg1_i[31];
        end
    end
    // architectural HI/LO and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_o <= 1'b0;
        end else begin
            if (wr_hi) hi_q <= hi_nxt;
            if (wr_lo) lo_q <= lo_nxt;
            done_o <= wr_res;
        end
    end
`ifdef HILO_FWD_EN
    assign hi_o = wr_hi ? hi_nxt : hi_q;
    assign lo_o = wr_lo ? lo_nxt : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    muldiv_op_t  op = OP_NONE;
    logic [31:0] r1 = '0;
    logic [31:0] r2 = '0;
    logic        cancel = 1'b0;
    logic        ready, done;
    logic [31:0] hi, lo;
    int          n_checks = 0;
    int          n_fail = 0;
    always #5 clk = ~clk;
    hilo_muldiv_unit #(.MUL_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid),
        .op_i     (op),
        .reg1_i   (r1),
        .reg2_i   (r2),
        .cancel_i (cancel),
        .ready_o  (ready),
        .hi_o     (hi),
        .lo_o     (lo),
        .done_o   (done)
    );
    task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                          output int low, output int dn);
        low = 0;
        dn  = 0;
        @(negedge clk);
        valid = 1'b1; op = o; r1 = a; r2 = b;
        @(negedge clk);
        valid = 1'b0; op = OP_NONE;
        while (!ready && low < 100) begin
            if (done) dn++;
            low++;
            @(negedge clk);
        end
        if (done) dn++;
        @(negedge clk);
        if (done) dn++;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        rst = 1'b0;
    endtask
    task automatic test_mthi_mtlo;
        @(negedge clk);
        valid = 1'b1; op = OP_MTHI; r1 = 32'h1234_5678;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mthi_ready got %b want 1", ready); end
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi got %h want 12345678", hi); end
        op = OP_MTLO; r1 = 32'h9ABC_DEF0;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mtlo_ready got %b want 1", ready); end
        n_checks++; if (lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo_lo got %h want 9abcdef0", lo); end
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi_kept got %h want 12345678", hi); end
        valid = 1'b0; op = OP_NONE;
        @(negedge clk);
        valid = 1'b1; op = OP_NONE; r1 = 32'hDEAD_BEEF;
        @(negedge clk);
        valid = 1'b0;
        n_checks++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || ready !== 1'b1)
            begin n_fail++; $display("FAIL op_none got hi=%h lo=%h rdy=%b want unchanged", hi, lo, ready); end
    endtask
    task automatic test_mult;
        int low, dn;
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, low, dn);
        n_checks++; if (low !== 2) begin n_fail++; $display("FAIL mult_stall got %0d want 2", low); end
        n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL mult_done got %0d want 1", dn); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo got %h want fffffffa", lo); end
        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, low, dn);
        n_checks++; if (low !== 2) begin n_fail++; $display("FAIL multu_stall got %0d want 2", low); end
        n_checks++; if (hi !== 32'h0000_0002) begin n_fail++; $display("FAIL multu_hi got %h want 00000002", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL multu_lo got %h want fffffffa", lo); end
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, low, dn);
        n_checks++; if (hi !== 32'h4000_0000 || lo !== 32'h0)
            begin n_fail++; $display("FAIL mult_minsq got %h_%h want 40000000_00000000", hi, lo); end
    endtask
    task automatic test_div;
        int low, dn;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, low, dn);
        n_checks++; if (low !== 33) begin n_fail++; $display("FAIL div_stall got %0d want 33", low); end
        n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL div_done got %0d want 1", dn); end
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi); end
        run_op(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, low, dn);
        n_checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'h1)
            begin n_fail++; $display("FAIL div_negdivisor got lo=%h hi=%h want fffffffd 1", lo, hi); end
        run_op(OP_DIVU, 32'd100, 32'd7, low, dn);
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %0d want 14", lo); end
        n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %0d want 2", hi); end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, low, dn);
        n_checks++; if (lo !== 32'h0000_FFFF || hi !== 32'h0000_FFFF)
            begin n_fail++; $display("FAIL divu_big got lo=%h hi=%h want 0000ffff 0000ffff", lo, hi); end
    endtask
    task automatic test_div_corner;
        int low, dn;
        run_op(OP_DIVU, 32'd5, 32'd0, low, dn);
        n_checks++; if (low !== 2) begin n_fail++; $display("FAIL divz_stall got %0d want 2", low); end
        n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL divz_done got %0d want 1", dn); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo got %h want ffffffff", lo); end
        n_checks++; if (hi !== 32'd5) begin n_fail++; $display("FAIL divz_hi got %h want 5", hi); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, low, dn);
        n_checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9)
            begin n_fail++; $display("FAIL divz_signed got lo=%h hi=%h want ffffffff fffffff9", lo, hi); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, low, dn);
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi got %h want 0", hi); end
    endtask
    task automatic test_cancel;
        int dn;
        @(negedge clk);
        valid = 1'b1; op = OP_MTHI; r1 = 32'hAAAA_AAAA;
        @(negedge clk);
        op = OP_MTLO;
        @(negedge clk);
        op = OP_DIVU; r1 = 32'd100; r2 = 32'd7;
        @(negedge clk);
        valid = 1'b0; op = OP_NONE;
        repeat (10) @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %b want 0", ready); end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL cancel_idle got %b want 1", ready); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL cancel_done got %0d want 0", dn); end
        n_checks++; if (hi !== 32'hAAAA_AAAA || lo !== 32'hAAAA_AAAA)
            begin n_fail++; $display("FAIL cancel_hilo got %h %h want aaaaaaaa", hi, lo); end
        valid = 1'b1; op = OP_MTHI; r1 = 32'h0000_0001; cancel = 1'b1;
        @(negedge clk);
        valid = 1'b0; op = OP_NONE; cancel = 1'b0;
        @(negedge clk);
        n_checks++; if (hi !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL cancel_mthi got %h want aaaaaaaa", hi); end
        valid = 1'b1; op = OP_MULTU; r1 = 32'd3; r2 = 32'd4;
        @(negedge clk);
        valid = 1'b0; op = OP_NONE;
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_checks++; if (ready !== 1'b1 || done !== 1'b0 || lo !== 32'hAAAA_AAAA)
            begin n_fail++; $display("FAIL cancel_completion got rdy=%b done=%b lo=%h want 1 0 aaaaaaaa", ready, done, lo); end
    endtask
    task automatic test_reset_mid_mul;
        @(negedge clk);
        valid = 1'b1; op = OP_MULTU; r1 = 32'd9; r2 = 32'd9;
        @(negedge clk);
        valid = 1'b0; op = OP_NONE; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL rst_mul_hilo got %h %h want 0 0", hi, lo); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_mul_ready got %b want 1", ready); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || lo !== 32'h0) begin n_fail++; $display("FAIL rst_mul_late got done=%b lo=%h want 0 0", done, lo); end
    endtask
    task automatic test_fwd;
        logic [31:0] exp_now;
`ifdef HILO_FWD_EN
        exp_now = 32'hCAFE_0000;
`else
        exp_now = 32'h0;
`endif
        @(negedge clk);
        valid = 1'b1; op = OP_MTHI; r1 = 32'hCAFE_0000;
        #1;
        n_checks++; if (hi !== exp_now) begin n_fail++; $display("FAIL fwd_same got %h want %h", hi, exp_now); end
        @(negedge clk);
        valid = 1'b0; op = OP_NONE;
        n_checks++; if (hi !== 32'hCAFE_0000) begin n_fail++; $display("FAIL fwd_next got %h want cafe0000", hi); end
    endtask
    initial begin
        #2_000_000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
    initial begin
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_div_corner();
        test_cancel();
        test_reset_mid_mul();
        test_fwd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
